// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - shared light codes, phase codes and timing defaults for the intersection scheduler
package intersection_pkg;

    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam logic [5:0] DFLT_GRE     = 6'd25;
    localparam logic [5:0] DFLT_YEL     = 6'd3;
    localparam logic [5:0] DFLT_CLR_T   = 6'd2;
    localparam logic [5:0] DFLT_MIN_GRE = 6'd5;
    localparam logic [5:0] DFLT_MAX_DUR = 6'd59;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_NS_GRN = 3'd1,
        ST_NS_YEL = 3'd2,
        ST_CLR_A  = 3'd3,
        ST_EW_GRN = 3'd4,
        ST_EW_YEL = 3'd5,
        ST_CLR_B  = 3'd6,
        ST_FLASH  = 3'd7
    } state_t;

endpackage

// File: rtl/intersection_sched_bin2bcd.sv
// rtl/intersection_sched_bin2bcd.sv - combinational 0..59 binary to two-digit BCD
module bin2bcd_60 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    assign tens = 4'(bin / 6'd10);
    assign ones = 4'(bin % 6'd10);

endmodule

// File: rtl/intersection_sched.sv
// rtl/intersection_sched.sv - two-road phase scheduler: one down-timer, config registers, ped shortening, flash mode
module intersection_sched
    import intersection_pkg::*;
#(
    parameter logic [5:0] DEF_GRE = DFLT_GRE,
    parameter logic [5:0] DEF_YEL = DFLT_YEL,
    parameter logic [5:0] CLR_T   = DFLT_CLR_T,
    parameter logic [5:0] MIN_GRE = DFLT_MIN_GRE,
    parameter logic [5:0] MAX_DUR = DFLT_MAX_DUR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       cfg_load,
    input  logic [5:0] cfg_gre,
    input  logic [5:0] cfg_yel,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [3:0] rem_tens,
    output logic [3:0] rem_ones,
    output logic [2:0] phase,
    output logic       cfg_err
);

    state_t     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic [5:0] gre_q, gre_d;
    logic [5:0] yel_q, yel_d;
    logic       ped_q, ped_d;
    logic       err_q, err_d;
    logic       tgl_q, tgl_d;
    logic [2:0] ns_q, ns_d;
    logic [2:0] ew_q, ew_d;
    logic       cfg_ok;
    logic       in_grn;

    assign cfg_ok = (cfg_gre >= MIN_GRE) && (cfg_gre <= MAX_DUR)
                 && (cfg_yel >= 6'd1) && (cfg_yel <= MAX_DUR);
    assign in_grn = (state_q == ST_NS_GRN) || (state_q == ST_EW_GRN);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gre_d   = gre_q;
        yel_d   = yel_q;
        ped_d   = ped_q | ped_req;
        err_d   = err_q;
        tgl_d   = tgl_q;
        ns_d    = L_RED;
        ew_d    = L_RED;

        if (cfg_load) begin
            if (cfg_ok) begin
                gre_d = cfg_gre;
                yel_d = cfg_yel;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (tick) begin
            if (state_q == ST_FLASH) begin
                if (!flash_en) state_d = ST_CLR_A;
                else           tgl_d   = ~tgl_q;
            end else if (timer_q == 6'd1) begin
                unique case (state_q)
                    ST_INIT, ST_CLR_B: state_d = flash_en ? ST_FLASH : ST_NS_GRN;
                    ST_NS_GRN:         state_d = ST_NS_YEL;
                    ST_NS_YEL:         state_d = ST_CLR_A;
                    ST_CLR_A:          state_d = flash_en ? ST_FLASH : ST_EW_GRN;
                    ST_EW_GRN:         state_d = ST_EW_YEL;
                    default:           state_d = ST_CLR_B;
                endcase
            end else if (in_grn && (ped_q | ped_req) && (timer_q > MIN_GRE)) begin
                timer_d = MIN_GRE;
            end else begin
                timer_d = timer_q - 6'd1;
            end
        end

        // Phase entry loads the duration stored before this edge, so a same-edge cfg_load waits.
        if (state_d != state_q) begin
            unique case (state_d)
                ST_NS_GRN, ST_EW_GRN: timer_d = gre_q;
                ST_NS_YEL, ST_EW_YEL: begin
                    timer_d = yel_q;
                    ped_d   = 1'b0;
                end
                ST_FLASH: begin
                    timer_d = 6'd0;
                    tgl_d   = 1'b0;
                end
                default: timer_d = CLR_T;
            endcase
        end
        if (state_d == ST_FLASH) ped_d = 1'b0;

        unique case (state_d)
            ST_NS_GRN: ns_d = L_GRN;
            ST_NS_YEL: ns_d = L_YEL;
            ST_EW_GRN: ew_d = L_GRN;
            ST_EW_YEL: ew_d = L_YEL;
            ST_FLASH: begin
                ns_d = tgl_d ? L_YEL : L_OFF;
                ew_d = tgl_d ? L_YEL : L_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            timer_q <= CLR_T;
            gre_q   <= DEF_GRE;
            yel_q   <= DEF_YEL;
            ped_q   <= 1'b0;
            err_q   <= 1'b0;
            tgl_q   <= 1'b0;
            ns_q    <= L_RED;
            ew_q    <= L_RED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gre_q   <= gre_d;
            yel_q   <= yel_d;
            ped_q   <= ped_d;
            err_q   <= err_d;
            tgl_q   <= tgl_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
        end
    end

    bin2bcd_60 u_bcd (
        .bin  (timer_q),
        .tens (rem_tens),
        .ones (rem_ones)
    );

    assign light_ns = ns_q;
    assign light_ew = ew_q;
    assign phase    = state_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_intersection_sched.sv
// tb/tb_intersection_sched.sv - table-driven directed bench for intersection_sched
module tb_intersection_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       cfg_load = 1'b0;
    logic [5:0] cfg_gre = '0;
    logic [5:0] cfg_yel = '0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] light_ns, light_ew, phase;
    logic [3:0] rem_tens, rem_ones;
    logic       cfg_err;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    intersection_sched dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .cfg_load (cfg_load),
        .cfg_gre  (cfg_gre),
        .cfg_yel  (cfg_yel),
        .ped_req  (ped_req),
        .flash_en (flash_en),
        .light_ns (light_ns),
        .light_ew (light_ew),
        .rem_tens (rem_tens),
        .rem_ones (rem_ones),
        .phase    (phase),
        .cfg_err  (cfg_err)
    );

    localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100, O = 3'b000;
    localparam logic [2:0] P_INIT = 3'd0, P_NSG = 3'd1, P_NSY = 3'd2, P_CLRA = 3'd3,
                           P_EWG = 3'd4, P_EWY = 3'd5, P_CLRB = 3'd6, P_FL = 3'd7;

    // n = number of tick cycles (pulses ride on the first); n = 0 means one idle cycle.
    typedef struct {
        logic       rst;
        logic       ld;
        logic [5:0] gre;
        logic [5:0] yel;
        logic       ped;
        logic       fl;
        int         n;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [2:0] ph;
        int         rem;
        logic       err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic r, input logic ld, input int g, input int y,
                                input logic p, input logic f, input int n,
                                input logic [2:0] ns, input logic [2:0] ew,
                                input logic [2:0] ph, input int rem, input logic err);
        vec_t v;
        v.rst = r; v.ld = ld; v.gre = 6'(g); v.yel = 6'(y); v.ped = p; v.fl = f; v.n = n;
        v.ns = ns; v.ew = ew; v.ph = ph; v.rem = rem; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [2:0] ns, input logic [2:0] ew,
                           input logic [2:0] ph, input int rem, input logic err);
        chk("light_ns", idx, int'(light_ns), int'(ns));
        chk("light_ew", idx, int'(light_ew), int'(ew));
        chk("phase",    idx, int'(phase),    int'(ph));
        chk("rem_tens", idx, int'(rem_tens), rem / 10);
        chk("rem_ones", idx, int'(rem_ones), rem % 10);
        chk("cfg_err",  idx, int'(cfg_err),  int'(err));
    endtask

    task automatic cyc(input logic t, input logic ld, input int g, input int y,
                       input logic p, input logic f, input logic r);
        tick = t; cfg_load = ld; cfg_gre = 6'(g); cfg_yel = 6'(y);
        ped_req = p; flash_en = f; rst = r;
        @(posedge clk);
        #1;
        tick = 1'b0; cfg_load = 1'b0; ped_req = 1'b0; rst = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        int cnt;
        cnt = (v.n == 0) ? 1 : v.n;
        for (int c = 0; c < cnt; c++) begin
            if (c == 0) cyc(v.n != 0, v.ld, v.gre, v.yel, v.ped, v.fl, v.rst);
            else        cyc(1'b1, 1'b0, 0, 0, 1'b0, v.fl, 1'b1);
        end
    endtask

    initial begin
        // reset and default sequence
        vt.push_back(mk(0,0, 0,0, 0,0,  0, R,R, P_INIT, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, R,R, P_INIT, 1, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, G,R, P_NSG, 25, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  5, G,R, P_NSG, 20, 0));
        // config mid-green: current phase keeps running
        vt.push_back(mk(1,1,10,4, 0,0,  0, G,R, P_NSG, 20, 0));
        vt.push_back(mk(1,0, 0,0, 0,0, 19, G,R, P_NSG,  1, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, Y,R, P_NSY,  4, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  4, R,R, P_CLRA, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, R,G, P_EWG, 10, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  9, R,G, P_EWG,  1, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, R,Y, P_EWY,  4, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  4, R,R, P_CLRB, 2, 0));
        // range check
        vt.push_back(mk(1,1, 3,4, 0,0,  0, R,R, P_CLRB, 2, 1));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, G,R, P_NSG, 10, 1));
        vt.push_back(mk(1,1,60,4, 0,0,  0, G,R, P_NSG, 10, 1));
        vt.push_back(mk(1,1,10,0, 0,0,  0, G,R, P_NSG, 10, 1));
        vt.push_back(mk(1,1, 8,2, 0,0,  0, G,R, P_NSG, 10, 0));
        // pedestrian shortening and the no-shorten case
        vt.push_back(mk(1,0, 0,0, 1,0,  0, G,R, P_NSG, 10, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, G,R, P_NSG,  5, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  4, G,R, P_NSG,  1, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, Y,R, P_NSY,  2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, R,R, P_CLRA, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, R,G, P_EWG,  8, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  4, R,G, P_EWG,  4, 0));
        vt.push_back(mk(1,0, 0,0, 1,0,  0, R,G, P_EWG,  4, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, R,G, P_EWG,  3, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  3, R,Y, P_EWY,  2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, R,R, P_CLRB, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, G,R, P_NSG,  8, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, G,R, P_NSG,  7, 0));
        // flash mode entered only after the clearance
        vt.push_back(mk(1,0, 0,0, 0,1,  0, G,R, P_NSG,  7, 0));
        vt.push_back(mk(1,0, 0,0, 0,1,  7, Y,R, P_NSY,  2, 0));
        vt.push_back(mk(1,0, 0,0, 0,1,  2, R,R, P_CLRA, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,1,  2, O,O, P_FL,   0, 0));
        vt.push_back(mk(1,0, 0,0, 0,1,  1, Y,Y, P_FL,   0, 0));
        vt.push_back(mk(1,0, 0,0, 0,1,  1, O,O, P_FL,   0, 0));
        vt.push_back(mk(1,0, 0,0, 0,1,  3, Y,Y, P_FL,   0, 0));
        vt.push_back(mk(1,0, 0,0, 1,1,  0, Y,Y, P_FL,   0, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  0, Y,Y, P_FL,   0, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, R,R, P_CLRA, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, R,G, P_EWG,  8, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  1, R,G, P_EWG,  7, 0));
        // reset mid-yellow restores defaults
        vt.push_back(mk(1,0, 0,0, 0,0,  7, R,Y, P_EWY,  2, 0));
        vt.push_back(mk(1,1, 0,1, 0,0,  0, R,Y, P_EWY,  2, 1));
        vt.push_back(mk(0,0, 0,0, 0,0,  0, R,R, P_INIT, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, G,R, P_NSG, 25, 0));
        // load on the same edge as a phase entry: entry keeps old yellow
        vt.push_back(mk(1,0, 0,0, 0,0, 24, G,R, P_NSG,  1, 0));
        vt.push_back(mk(1,1,12,5, 0,0,  1, Y,R, P_NSY,  3, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  3, R,R, P_CLRA, 2, 0));
        vt.push_back(mk(1,0, 0,0, 0,0,  2, R,G, P_EWG, 12, 0));

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i]);
            n_vec++;
            chk_all(i, vt[i].ns, vt[i].ew, vt[i].ph, vt[i].rem, vt[i].err);
        end

        // tick + cfg_load + ped_req together: shorten from current timer, new yellow at next entry
        cyc(1'b1, 1'b1, 20, 3, 1'b1, 1'b0, 1'b1);
        n_vec++;
        chk_all(100, R, G, P_EWG, 5, 0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        chk_all(101, R, G, P_EWG, 1, 0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        chk_all(102, R, Y, P_EWY, 3, 0);

        // flash request raised during a clearance but dropped before its last tick is ignored
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        chk_all(103, R, R, P_CLRB, 2, 0);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        chk_all(104, G, R, P_NSG, 20, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
